// File: rtl/alu_mc_pkg.sv
// Shared opcodes, op type and FSM state encoding for the multi-cycle ALU.
package alu_mc_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t OP_ADD  = 4'b0000;
  localparam alu_op_t OP_SUB  = 4'b0001;
  localparam alu_op_t OP_AND  = 4'b0010;
  localparam alu_op_t OP_OR   = 4'b0011;
  localparam alu_op_t OP_SLTU = 4'b0100;
  localparam alu_op_t OP_SLT  = 4'b0101;
  localparam alu_op_t OP_XOR  = 4'b0110;
  localparam alu_op_t OP_NOR  = 4'b0111;
  localparam alu_op_t OP_SLL  = 4'b1000;
  localparam alu_op_t OP_SRL  = 4'b1001;
  localparam alu_op_t OP_SRA  = 4'b1010;
  localparam alu_op_t OP_MUL  = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mc_mul.sv
// Iterative shift-add multiplier returning the low WIDTH bits of a*b.
// The start edge performs the first step, so the product is ready after WIDTH-1 busy cycles.
module alu_mc_mul #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_sum;

  always_comb begin
    acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = CW'(WIDTH - 1);
      acc_d    = b[0] ? a : '0;
      mcand_d  = a << 1;
      mplier_d = b >> 1;
    end else if (busy_q) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - 1'b1;
      // Counter lands on zero with the final step, so it never wraps.
      if (cnt_q == CW'(1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == CW'(1));
  assign product = acc_sum;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake and registered result/flags.
// Define ALU_MC_MUL_EN to enable the iterative MUL; otherwise opcode 1011 decodes as ADD.
//
// state   | meaning
// IDLE    | ready for a new op, no result pending
// MUL     | iterative multiply in progress, not ready
// DONE    | result valid and held until out_ready
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             ovf
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic             is_mul;
  logic             mul_busy;
  logic [WIDTH:0]   sum_w, diff_w;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry, alu_ovf;

`ifdef ALU_MC_MUL_EN
  logic             mul_start, mul_done;
  logic [WIDTH-1:0] mul_product;

  assign is_mul    = (alu_ctrl == OP_MUL);
  assign mul_start = accept && is_mul;

  alu_mc_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign is_mul   = 1'b0;
  assign mul_busy = 1'b0;
`endif

  assign in_ready = !mul_busy &&
                    ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    sum_w     = {1'b0, a} + {1'b0, b};
    diff_w    = {1'b0, a} - {1'b0, b};
    shamt     = b[SHW-1:0];
    alu_res   = sum_w[WIDTH-1:0];
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (alu_ctrl)
      OP_SUB: begin
        alu_res   = diff_w[WIDTH-1:0];
        alu_carry = diff_w[WIDTH];
        alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, diff_w[WIDTH]};
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
      default: begin
        alu_carry = sum_w[WIDTH];
        alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (is_mul) begin
            state_d     = ST_MUL;
            out_valid_d = 1'b0;
          end else begin
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            carry_d     = alu_carry;
            ovf_d       = alu_ovf;
          end
        end else if ((state_q == ST_DONE) && out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
`ifdef ALU_MC_MUL_EN
      ST_MUL: begin
        if (mul_done) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          result_d    = mul_product;
          zero_d      = (mul_product == '0);
          carry_d     = 1'b0;
          ovf_d       = 1'b0;
        end
      end
`endif
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;

endmodule
